// File: rtl/cs_microsequencer_pkg.sv
// Shared microsequencer definitions: sequencing op encodings and the opcode-to-entry-point mapping.
package cs_microsequencer_pkg;

   localparam logic [2:0] OP_NEXT   = 3'b000;
   localparam logic [2:0] OP_JUMP   = 3'b001;
   localparam logic [2:0] OP_DECODE = 3'b010;
   localparam logic [2:0] OP_BRANCH = 3'b011;
   localparam logic [2:0] OP_CALL   = 3'b100;
   localparam logic [2:0] OP_RETURN = 3'b101;
   localparam logic [2:0] OP_HOLD   = 3'b110;

   // Entry point {1, zero pad, opcode, 2'b00}; caller truncates to its address width.
   function automatic logic [31:0] dec_map(input logic [31:0] opcode,
                                           input int unsigned addr_length);
      return (32'd1 << (addr_length - 1)) | (opcode << 2);
   endfunction

endpackage

// File: rtl/cs_microsequencer_if.sv
// Sequencer control/status bundle: MIR-side controls in, control-store address and stack status out.
interface cs_microsequencer_if #(
   parameter int unsigned ADDR_LENGTH     = 11,
   parameter int unsigned DECODER_LENGTH  = 8,
   parameter int unsigned COND_LENGTH     = 4,
   parameter int unsigned COND_SEL_LENGTH = 2
);
   logic [2:0]                 CS_MICROSEQUENCER_op_InBUS;
   logic [ADDR_LENGTH-1:0]     CS_MICROSEQUENCER_data_MIR;
   logic [DECODER_LENGTH-1:0]  CS_MICROSEQUENCER_data_Scratchpad;
   logic [COND_LENGTH-1:0]     CS_MICROSEQUENCER_cond_InBUS;
   logic [COND_SEL_LENGTH-1:0] CS_MICROSEQUENCER_condSel_InBUS;
   logic                       CS_MICROSEQUENCER_condInv_InLow;
   logic                       CS_MICROSEQUENCER_stall_InHigh;
   logic [ADDR_LENGTH-1:0]     CS_MICROSEQUENCER_addr_OutBUS;
   logic [ADDR_LENGTH-1:0]     CS_MICROSEQUENCER_next_OutBUS;
   logic                       CS_MICROSEQUENCER_stackFull_OutHigh;
   logic                       CS_MICROSEQUENCER_stackEmpty_OutHigh;
   logic                       CS_MICROSEQUENCER_error_OutHigh;

   modport master (
      output CS_MICROSEQUENCER_op_InBUS, CS_MICROSEQUENCER_data_MIR,
             CS_MICROSEQUENCER_data_Scratchpad, CS_MICROSEQUENCER_cond_InBUS,
             CS_MICROSEQUENCER_condSel_InBUS, CS_MICROSEQUENCER_condInv_InLow,
             CS_MICROSEQUENCER_stall_InHigh,
      input  CS_MICROSEQUENCER_addr_OutBUS, CS_MICROSEQUENCER_next_OutBUS,
             CS_MICROSEQUENCER_stackFull_OutHigh, CS_MICROSEQUENCER_stackEmpty_OutHigh,
             CS_MICROSEQUENCER_error_OutHigh
   );

   modport slave (
      input  CS_MICROSEQUENCER_op_InBUS, CS_MICROSEQUENCER_data_MIR,
             CS_MICROSEQUENCER_data_Scratchpad, CS_MICROSEQUENCER_cond_InBUS,
             CS_MICROSEQUENCER_condSel_InBUS, CS_MICROSEQUENCER_condInv_InLow,
             CS_MICROSEQUENCER_stall_InHigh,
      output CS_MICROSEQUENCER_addr_OutBUS, CS_MICROSEQUENCER_next_OutBUS,
             CS_MICROSEQUENCER_stackFull_OutHigh, CS_MICROSEQUENCER_stackEmpty_OutHigh,
             CS_MICROSEQUENCER_error_OutHigh
   );
endinterface

// File: rtl/cs_return_stack.sv
// LIFO microsubroutine return-address stack; refuses push when full and pop when empty,
// reporting each refusal as a one-cycle pulse.
module cs_return_stack #(
   parameter int unsigned ADDR_LENGTH = 11,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [ADDR_LENGTH-1:0] data_i,
   output logic [ADDR_LENGTH-1:0] top_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic                   overflow_o,
   output logic                   underflow_o
);
   localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [CntW-1:0]        count_q, count_d;
   logic [ADDR_LENGTH-1:0] mem_q [STACK_DEPTH];
   logic                   do_push, do_pop;
   logic [IdxW-1:0]        wr_idx, top_idx;

   assign full_o      = (count_q == CntW'(STACK_DEPTH));
   assign empty_o     = (count_q == '0);
   assign do_push     = push_i & ~full_o;
   assign do_pop      = pop_i & ~empty_o;
   assign overflow_o  = push_i & full_o;
   assign underflow_o = pop_i & empty_o;
   assign wr_idx      = IdxW'(count_q);
   assign top_idx     = IdxW'(count_q - CntW'(1));
   assign top_o       = mem_q[top_idx];

   always_comb begin
      count_d = count_q;
      if (do_push) begin
         count_d = count_q + CntW'(1);
      end else if (do_pop) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Entries are only valid below count_q, so the storage needs no reset.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_idx] <= data_i;
      end
   end

endmodule

// File: rtl/cs_microsequencer.sv
// Control-store microsequencer: next-address selection, registered current address,
// return stack and sticky stack error flag.
module cs_microsequencer
   import cs_microsequencer_pkg::*;
#(
   parameter int unsigned          ADDR_LENGTH     = 11,
   parameter int unsigned          DECODER_LENGTH  = 8,
   parameter int unsigned          COND_LENGTH     = 4,
   parameter int unsigned          COND_SEL_LENGTH = 2,
   parameter int unsigned          STACK_DEPTH     = 4,
   parameter logic [ADDR_LENGTH-1:0] RESET_ADDR    = '0
) (
   input logic               CS_MICROSEQUENCER_CLOCK_50,
   input logic               CS_MICROSEQUENCER_RESET_InHigh,
   cs_microsequencer_if.slave seq_bus
);
   logic [2:0]                 op;
   logic [COND_SEL_LENGTH-1:0] cond_sel;
   logic                       stall;
   logic [ADDR_LENGTH-1:0]     addr_q, addr_d;
   logic                       error_q, error_d;
   logic [ADDR_LENGTH-1:0]     inc_addr, dec_addr, next_addr, stack_top;
   logic                       flag, taken;
   logic                       push, pop;
   logic                       stack_full, stack_empty, overflow, underflow;

   assign op       = seq_bus.CS_MICROSEQUENCER_op_InBUS;
   assign cond_sel = seq_bus.CS_MICROSEQUENCER_condSel_InBUS;
   assign stall    = seq_bus.CS_MICROSEQUENCER_stall_InHigh;
   assign inc_addr = addr_q + ADDR_LENGTH'(1);
   assign dec_addr = ADDR_LENGTH'(dec_map(32'(seq_bus.CS_MICROSEQUENCER_data_Scratchpad),
                                          ADDR_LENGTH));

   // Selects beyond the implemented flags read as zero.
   always_comb begin
      flag = 1'b0;
      for (int unsigned i = 0; i < COND_LENGTH; i++) begin
         if (cond_sel == COND_SEL_LENGTH'(i)) begin
            flag = seq_bus.CS_MICROSEQUENCER_cond_InBUS[i];
         end
      end
   end

   assign taken = (flag == seq_bus.CS_MICROSEQUENCER_condInv_InLow);

   always_comb begin
      next_addr = inc_addr;
      push      = 1'b0;
      pop       = 1'b0;
      case (op)
         OP_JUMP:   next_addr = seq_bus.CS_MICROSEQUENCER_data_MIR;
         OP_DECODE: next_addr = dec_addr;
         OP_BRANCH: next_addr = taken ? seq_bus.CS_MICROSEQUENCER_data_MIR : inc_addr;
         OP_CALL: begin
            next_addr = seq_bus.CS_MICROSEQUENCER_data_MIR;
            push      = ~stall;
         end
         OP_RETURN: begin
            next_addr = stack_empty ? inc_addr : stack_top;
            pop       = ~stall;
         end
         OP_HOLD:   next_addr = addr_q;
         default:   next_addr = inc_addr;
      endcase
   end

   assign addr_d  = stall ? addr_q : next_addr;
   assign error_d = error_q | overflow | underflow;

   always_ff @(posedge CS_MICROSEQUENCER_CLOCK_50 or posedge CS_MICROSEQUENCER_RESET_InHigh) begin
      if (CS_MICROSEQUENCER_RESET_InHigh) begin
         addr_q  <= RESET_ADDR;
         error_q <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         error_q <= error_d;
      end
   end

   cs_return_stack #(
      .ADDR_LENGTH (ADDR_LENGTH),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_return_stack (
      .clk_i       (CS_MICROSEQUENCER_CLOCK_50),
      .rst_i       (CS_MICROSEQUENCER_RESET_InHigh),
      .push_i      (push),
      .pop_i       (pop),
      .data_i      (inc_addr),
      .top_o       (stack_top),
      .full_o      (stack_full),
      .empty_o     (stack_empty),
      .overflow_o  (overflow),
      .underflow_o (underflow)
   );

   assign seq_bus.CS_MICROSEQUENCER_addr_OutBUS        = addr_q;
   assign seq_bus.CS_MICROSEQUENCER_next_OutBUS        = next_addr;
   assign seq_bus.CS_MICROSEQUENCER_stackFull_OutHigh  = stack_full;
   assign seq_bus.CS_MICROSEQUENCER_stackEmpty_OutHigh = stack_empty;
   assign seq_bus.CS_MICROSEQUENCER_error_OutHigh      = error_q;

endmodule

// File: tb/tb_cs_microsequencer.sv
// Self-checking bench for cs_microsequencer: directed vector table, hand-written
// stack/stall/reset sequences, and randomized stimulus against a queue-based model.
module tb_cs_microsequencer;
   localparam int unsigned AW = 11, DW = 8, CW = 4, CSW = 2, DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cs_microsequencer_if #(
      .ADDR_LENGTH (AW), .DECODER_LENGTH (DW), .COND_LENGTH (CW), .COND_SEL_LENGTH (CSW)
   ) bus ();

   cs_microsequencer #(
      .ADDR_LENGTH (AW), .DECODER_LENGTH (DW), .COND_LENGTH (CW), .COND_SEL_LENGTH (CSW),
      .STACK_DEPTH (DEPTH), .RESET_ADDR (11'h000)
   ) dut (
      .CS_MICROSEQUENCER_CLOCK_50     (clk),
      .CS_MICROSEQUENCER_RESET_InHigh (rst),
      .seq_bus                        (bus)
   );

   int compared = 0;
   int mismatched = 0;

   // Reference model: current address, return stack as a queue, sticky error.
   int unsigned m_addr;
   int unsigned m_stack[$];
   bit          m_err;

   typedef struct {
      logic [2:0]  op;
      logic [10:0] mir;
      logic [7:0]  sp;
      logic [3:0]  cond;
      logic [1:0]  csel;
      logic        cinv;
      logic [10:0] exp_next;
      logic [10:0] exp_addr;
      logic        exp_empty;
      logic        exp_err;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [10:0] mir, input logic [7:0] sp,
                        input logic [3:0] cond, input logic [1:0] csel, input logic cinv,
                        input logic stall);
      bus.CS_MICROSEQUENCER_op_InBUS        = op;
      bus.CS_MICROSEQUENCER_data_MIR        = mir;
      bus.CS_MICROSEQUENCER_data_Scratchpad = sp;
      bus.CS_MICROSEQUENCER_cond_InBUS      = cond;
      bus.CS_MICROSEQUENCER_condSel_InBUS   = csel;
      bus.CS_MICROSEQUENCER_condInv_InLow   = cinv;
      bus.CS_MICROSEQUENCER_stall_InHigh    = stall;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op_step(input logic [2:0] op, input logic [10:0] mir);
      drive(op, mir, 8'h00, 4'h0, 2'd0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(3'd0, 11'h0, 8'h0, 4'h0, 2'd0, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_addr = 0;
      m_stack.delete();
      m_err = 1'b0;
   endtask

   function automatic int unsigned model_next(input int unsigned op, input int unsigned mir,
                                              input int unsigned sp, input int unsigned cond,
                                              input int unsigned csel, input int unsigned cinv);
      int unsigned inc = (m_addr + 1) % (1 << AW);
      int unsigned flag = (csel < CW) ? ((cond >> csel) & 1) : 0;
      case (op)
         1:       return mir;
         2:       return (1 << (AW - 1)) + sp * 4;
         3:       return (flag == cinv) ? mir : inc;
         4:       return mir;
         5:       return (m_stack.size() > 0) ? m_stack[$] : inc;
         6:       return m_addr;
         default: return inc;
      endcase
   endfunction

   task automatic model_commit(input int unsigned op, input bit stall, input int unsigned nxt);
      int unsigned inc = (m_addr + 1) % (1 << AW);
      if (!stall) begin
         if (op == 4) begin
            if (m_stack.size() < DEPTH) m_stack.push_back(inc);
            else m_err = 1'b1;
         end else if (op == 5) begin
            if (m_stack.size() > 0) void'(m_stack.pop_back());
            else m_err = 1'b1;
         end
         m_addr = nxt;
      end
   endtask

   initial begin
      int unsigned ret_exp[4];
      int unsigned r_op, r_mir, r_sp, r_cond, r_csel, r_cinv, r_nxt;
      bit          r_stall;

      //           op    mir     sp     cond   csel cinv next    addr    emp  err
      vecs[0]  = '{3'd0, 11'h000, 8'h00, 4'h0, 2'd0, 1'b0, 11'h001, 11'h001, 1'b1, 1'b0};
      vecs[1]  = '{3'd0, 11'h000, 8'h00, 4'h0, 2'd0, 1'b0, 11'h002, 11'h002, 1'b1, 1'b0};
      vecs[2]  = '{3'd0, 11'h000, 8'h00, 4'h0, 2'd0, 1'b0, 11'h003, 11'h003, 1'b1, 1'b0};
      vecs[3]  = '{3'd1, 11'h7FF, 8'h00, 4'h0, 2'd0, 1'b0, 11'h7FF, 11'h7FF, 1'b1, 1'b0};
      vecs[4]  = '{3'd0, 11'h000, 8'h00, 4'h0, 2'd0, 1'b0, 11'h000, 11'h000, 1'b1, 1'b0};
      vecs[5]  = '{3'd2, 11'h000, 8'hA5, 4'h0, 2'd0, 1'b0, 11'h694, 11'h694, 1'b1, 1'b0};
      vecs[6]  = '{3'd3, 11'h100, 8'h00, 4'h2, 2'd1, 1'b1, 11'h100, 11'h100, 1'b1, 1'b0};
      vecs[7]  = '{3'd3, 11'h100, 8'h00, 4'h0, 2'd1, 1'b1, 11'h101, 11'h101, 1'b1, 1'b0};
      vecs[8]  = '{3'd1, 11'h010, 8'h00, 4'h0, 2'd0, 1'b0, 11'h010, 11'h010, 1'b1, 1'b0};
      vecs[9]  = '{3'd4, 11'h200, 8'h00, 4'h0, 2'd0, 1'b0, 11'h200, 11'h200, 1'b0, 1'b0};
      vecs[10] = '{3'd4, 11'h300, 8'h00, 4'h0, 2'd0, 1'b0, 11'h300, 11'h300, 1'b0, 1'b0};
      vecs[11] = '{3'd5, 11'h000, 8'h00, 4'h0, 2'd0, 1'b0, 11'h201, 11'h201, 1'b0, 1'b0};
      vecs[12] = '{3'd5, 11'h000, 8'h00, 4'h0, 2'd0, 1'b0, 11'h011, 11'h011, 1'b1, 1'b0};

      do_reset();
      check("reset_addr", 32'(bus.CS_MICROSEQUENCER_addr_OutBUS), 32'h000);
      check("reset_empty", 32'(bus.CS_MICROSEQUENCER_stackEmpty_OutHigh), 32'h1);
      check("reset_full", 32'(bus.CS_MICROSEQUENCER_stackFull_OutHigh), 32'h0);
      check("reset_error", 32'(bus.CS_MICROSEQUENCER_error_OutHigh), 32'h0);

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].op, vecs[i].mir, vecs[i].sp, vecs[i].cond, vecs[i].csel, vecs[i].cinv,
               1'b0);
         #2;
         check($sformatf("vec%0d_next", i), 32'(bus.CS_MICROSEQUENCER_next_OutBUS),
               32'(vecs[i].exp_next));
         tick();
         check($sformatf("vec%0d_addr", i), 32'(bus.CS_MICROSEQUENCER_addr_OutBUS),
               32'(vecs[i].exp_addr));
         check($sformatf("vec%0d_empty", i), 32'(bus.CS_MICROSEQUENCER_stackEmpty_OutHigh),
               32'(vecs[i].exp_empty));
         check($sformatf("vec%0d_err", i), 32'(bus.CS_MICROSEQUENCER_error_OutHigh),
               32'(vecs[i].exp_err));
      end

      // Overflow: four calls fill the stack, the fifth still jumps but flags error.
      do_reset();
      op_step(3'd4, 11'h020);
      op_step(3'd4, 11'h030);
      op_step(3'd4, 11'h040);
      op_step(3'd4, 11'h050);
      check("ovf_full4", 32'(bus.CS_MICROSEQUENCER_stackFull_OutHigh), 32'h1);
      check("ovf_err4", 32'(bus.CS_MICROSEQUENCER_error_OutHigh), 32'h0);
      op_step(3'd4, 11'h060);
      check("ovf_addr5", 32'(bus.CS_MICROSEQUENCER_addr_OutBUS), 32'h060);
      check("ovf_err5", 32'(bus.CS_MICROSEQUENCER_error_OutHigh), 32'h1);
      check("ovf_full5", 32'(bus.CS_MICROSEQUENCER_stackFull_OutHigh), 32'h1);
      ret_exp = '{32'h041, 32'h031, 32'h021, 32'h001};
      for (int i = 0; i < 4; i++) begin
         op_step(3'd5, 11'h000);
         check($sformatf("ovf_ret%0d", i), 32'(bus.CS_MICROSEQUENCER_addr_OutBUS),
               32'(ret_exp[i]));
      end
      check("ovf_empty", 32'(bus.CS_MICROSEQUENCER_stackEmpty_OutHigh), 32'h1);
      op_step(3'd1, 11'h050);
      op_step(3'd5, 11'h000);
      check("unf_addr", 32'(bus.CS_MICROSEQUENCER_addr_OutBUS), 32'h051);
      check("unf_err", 32'(bus.CS_MICROSEQUENCER_error_OutHigh), 32'h1);
      op_step(3'd0, 11'h000);
      op_step(3'd0, 11'h000);
      op_step(3'd0, 11'h000);
      check("sticky_addr", 32'(bus.CS_MICROSEQUENCER_addr_OutBUS), 32'h054);
      check("sticky_err", 32'(bus.CS_MICROSEQUENCER_error_OutHigh), 32'h1);

      // Stall during CALL, then asynchronous reset mid-cycle.
      do_reset();
      check("rst_clears_err", 32'(bus.CS_MICROSEQUENCER_error_OutHigh), 32'h0);
      op_step(3'd1, 11'h010);
      drive(3'd4, 11'h200, 8'h00, 4'h0, 2'd0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #2;
         check($sformatf("stall%0d_next", i), 32'(bus.CS_MICROSEQUENCER_next_OutBUS), 32'h200);
         tick();
         check($sformatf("stall%0d_addr", i), 32'(bus.CS_MICROSEQUENCER_addr_OutBUS), 32'h010);
         check($sformatf("stall%0d_empty", i),
               32'(bus.CS_MICROSEQUENCER_stackEmpty_OutHigh), 32'h1);
      end
      op_step(3'd4, 11'h200);
      check("unstall_addr", 32'(bus.CS_MICROSEQUENCER_addr_OutBUS), 32'h200);
      check("unstall_empty", 32'(bus.CS_MICROSEQUENCER_stackEmpty_OutHigh), 32'h0);
      drive(3'd0, 11'h000, 8'h00, 4'h0, 2'd0, 1'b0, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_addr", 32'(bus.CS_MICROSEQUENCER_addr_OutBUS), 32'h000);
      check("async_rst_empty", 32'(bus.CS_MICROSEQUENCER_stackEmpty_OutHigh), 32'h1);
      @(negedge clk);

      // Randomized run against the queue model, with periodic resets.
      do_reset();
      for (int n = 0; n < 600; n++) begin
         if (n % 150 == 149) do_reset();
         r_op    = $urandom_range(0, 7);
         r_mir   = $urandom_range(0, (1 << AW) - 1);
         r_sp    = $urandom_range(0, 255);
         r_cond  = $urandom_range(0, 15);
         r_csel  = $urandom_range(0, 3);
         r_cinv  = $urandom_range(0, 1);
         r_stall = ($urandom_range(0, 7) == 0);
         drive(3'(r_op), 11'(r_mir), 8'(r_sp), 4'(r_cond), 2'(r_csel), 1'(r_cinv), r_stall);
         r_nxt = model_next(r_op, r_mir, r_sp, r_cond, r_csel, r_cinv);
         #2;
         check($sformatf("rnd%0d_next", n), 32'(bus.CS_MICROSEQUENCER_next_OutBUS), r_nxt);
         tick();
         model_commit(r_op, r_stall, r_nxt);
         check($sformatf("rnd%0d_addr", n), 32'(bus.CS_MICROSEQUENCER_addr_OutBUS), m_addr);
         check($sformatf("rnd%0d_full", n), 32'(bus.CS_MICROSEQUENCER_stackFull_OutHigh),
               32'(m_stack.size() == DEPTH));
         check($sformatf("rnd%0d_empty", n), 32'(bus.CS_MICROSEQUENCER_stackEmpty_OutHigh),
               32'(m_stack.size() == 0));
         check($sformatf("rnd%0d_err", n), 32'(bus.CS_MICROSEQUENCER_error_OutHigh),
               32'(m_err));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/cs_microsequencer.md
Name: cs_microsequencer

Overview:
- Parametrised microsequencer address unit for the control store.
- Holds the registered current control-store address.
- Each cycle it selects the next address from one of these sources:
  - incrementer (current address + 1)
  - MIR jump field
  - opcode-decoder mapping
  - a condition-tested branch
  - a microsubroutine return stack
- It feeds the control-store ROM address directly.
- It adds conditional branching, microcall/return, stall and error reporting on top of plain source selection.

Parameters:
- ADDR_LENGTH, 11, control-store address width.
- DECODER_LENGTH, 8, opcode width from the scratchpad/IR. Constraint: ADDR_LENGTH >= DECODER_LENGTH+3.
- COND_LENGTH, 4, number of condition flags.
- COND_SEL_LENGTH, 2, width of the condition select; 2^COND_SEL_LENGTH >= COND_LENGTH.
- STACK_DEPTH, 4, return-stack entries (>=1).
- RESET_ADDR, 0, address loaded on reset.

Ports:
- CS_MICROSEQUENCER_CLOCK_50  in  1  system clock, rising edge.
- CS_MICROSEQUENCER_RESET_InHigh  in  1  asynchronous active-high reset.
- CS_MICROSEQUENCER_op_InBUS  in  3  sequencing operation from the MIR.
- CS_MICROSEQUENCER_data_MIR  in  ADDR_LENGTH  jump/branch/call target.
- CS_MICROSEQUENCER_data_Scratchpad  in  DECODER_LENGTH  opcode for DECODE.
- CS_MICROSEQUENCER_cond_InBUS  in  COND_LENGTH  condition flags (ALU N/Z etc.).
- CS_MICROSEQUENCER_condSel_InBUS  in  COND_SEL_LENGTH  flag index for BRANCH.
- CS_MICROSEQUENCER_condInv_InLow  in  1  0 = branch on flag==0, 1 = branch on flag==1.
- CS_MICROSEQUENCER_stall_InHigh  in  1  freeze sequencer.
- CS_MICROSEQUENCER_addr_OutBUS  out  ADDR_LENGTH  registered current address.
- CS_MICROSEQUENCER_next_OutBUS  out  ADDR_LENGTH  combinational next address.
- CS_MICROSEQUENCER_stackFull_OutHigh  out  1  stack count == STACK_DEPTH.
- CS_MICROSEQUENCER_stackEmpty_OutHigh  out  1  stack count == 0.
- CS_MICROSEQUENCER_error_OutHigh  out  1  sticky overflow/underflow flag.

Behaviour:
- Clocking and reset:
  - One clock, CS_MICROSEQUENCER_CLOCK_50.
  - CS_MICROSEQUENCER_RESET_InHigh is asynchronous and active-high.
  - Reset values: addr = RESET_ADDR, stack count = 0, error = 0, stackEmpty = 1, stackFull = 0. Stack storage contents are don't-care.
  - Reset asserted mid-operation aborts any pending call/return immediately.
- Decode mapping: DEC = {1'b1, zero pad, opcode, 2'b00}, total ADDR_LENGTH bits.
- INC = addr + 1, modulo 2^ADDR_LENGTH. 2^ADDR_LENGTH-1 wraps to 0.
- Condition: TAKEN = (cond[condSel] == condInv).
  - If condSel >= COND_LENGTH, the flag reads as 0.
- next_OutBUS by op:
  - 000 NEXT: INC.
  - 001 JUMP: MIR.
  - 010 DECODE: DEC.
  - 011 BRANCH: MIR if TAKEN, else INC.
  - 100 CALL: MIR. On the clock edge, push INC.
  - 101 RETURN: top of stack. On the clock edge, pop.
  - 110 HOLD: addr (no change).
  - 111 reserved: treated as NEXT.
- Rising edge, stall = 0: addr <= next_OutBUS and stack updates apply.
- Rising edge, stall = 1: addr, stack and error hold. next_OutBUS still reflects op, but is not committed.
- Latency: addr_OutBUS changes one cycle after op is presented. next_OutBUS is zero-latency, for synchronous ROM address.
- Stack boundaries:
  - CALL with stack full (overflow): no push, jump to MIR still taken, error <= 1.
  - RETURN with stack empty (underflow): next = INC, no pop, error <= 1.
  - error clears only on reset.
- Stack is LIFO; the top entry is the last pushed.
- Only one stack operation is possible per cycle (op is exclusive), so there are no simultaneous push and pop.

Decomposition:
- Shared package holds the op encodings as localparams: OP_NEXT, OP_JUMP, OP_DECODE, OP_BRANCH, OP_CALL, OP_RETURN, OP_HOLD.
- The same package holds the DEC mapping as a function, shared with the assembler-side constants.
- One sub-module: cs_return_stack.
  - Parametrised by ADDR_LENGTH and STACK_DEPTH.
  - Inputs: push, pop, data. Outputs: top, full, empty, plus separate overflow and underflow pulses.
- Next-address mux and address register live in the top module.

Test Plan:
1. Reset then NEXT for 3 cycles -> addr 0,1,2,3. Set op JUMP with MIR=0x7FF, then NEXT -> addr 0x7FF then 0x000 (wrap).
2. DECODE with Scratchpad=0xA5 (defaults) -> next 0x694, and addr=0x694 after the edge.
3. BRANCH condSel=1, condInv=1:
   - With cond=4'b0010 and MIR=0x100 -> addr 0x100.
   - With cond=4'b0000 at addr 0x100 -> addr 0x101.
4. At addr 0x010: CALL MIR=0x200, then at 0x200 CALL MIR=0x300, then RETURN, RETURN -> addr sequence 0x200, 0x300, 0x201, 0x011. stackEmpty=1 at end, error=0.
5. Five CALLs with STACK_DEPTH=4 -> stackFull=1 after the 4th and error=1 after the 5th, jump still taken. RETURN on empty stack from 0x050 -> 0x051, error remains 1 until reset.
6. Stall=1 held 3 cycles during CALL -> addr and stack count unchanged, next_OutBUS=MIR. Assert reset asynchronously mid-cycle -> addr=0 and stackEmpty=1 immediately, before the next edge.
